pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the core's halt control.
- Single owner of the stall, flush, forwarding-select and halt-drain decisions for an N-stage in-order pipeline. Stage 0 is IF, stage 1 is ID, stage 2 is EX, and so on.
- Replaces the fixed 5-bit halt vector with per-stage stall and flush vectors, configurable load-use latency, a halt drain sequence, restart, and a stall performance counter.

Parameters:
STAGES, 5, pipeline depth (>=4); width of stall/flush vectors
FLUSH_DEPTH, 2, number of stages from stage 0 flushed on taken branch (1..STAGES-2)
LOAD_LAT, 1, load-use bubbles inserted (1..4)
REG_AW, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_AW  ID source 1 address
id_rs2  in  REG_AW  ID source 2 address
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_halt  in  1  ID instruction is a halt
ex_valid  in  1  EX holds a real instruction
ex_rd  in  REG_AW  EX destination
ex_reg_write  in  1  EX instruction writes rd
ex_is_load  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved taken branch/jump
mem_valid  in  1  MEM stage valid
mem_rd  in  REG_AW  MEM destination
mem_reg_write  in  1  MEM writes rd
wb_valid  in  1  WB stage valid
wb_rd  in  REG_AW  WB destination
wb_reg_write  in  1  WB writes rd
restart  in  1  leave HALTED
stall  out  STAGES  bit i: stage i register holds
flush  out  STAGES  bit i: stage i register loads a bubble
fwd_rs1  out  2  0 = regfile, 1 = from MEM, 2 = from WB, 3 unused
fwd_rs2  out  2  same encoding for rs2
halted  out  1  pipeline drained and frozen
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Timing:
  - stall, flush and fwd_* are combinational from the current state and inputs.
  - State, counters and halted update on the rising clk edge.
- Reset (rst=0 at an edge): state=RUN, drain/bubble counters=0, stall_count=0, halted=0.
  - While rst=0, the outputs are stall=0, flush=all ones and fwd=0.
  - A reset asserted in any state, including mid-drain, wins.
- load_use is true when all of the following hold:
  - id_valid & ex_valid & ex_is_load & ex_reg_write & ex_rd!=0;
  - and either (id_use_rs1 & id_rs1==ex_rd) or (id_use_rs2 & id_rs2==ex_rd).
- Forwarding, evaluated per source and in every state:
  - Select 1 if mem_valid & mem_reg_write & mem_rd!=0 & mem_rd==src.
  - Otherwise select 2 under the same condition on WB.
  - Otherwise select 0.
  - MEM has priority over WB. x0 is never forwarded.
- State RUN, with decisions in priority order:
  - ex_branch_taken: flush[FLUSH_DEPTH-1:0]=1, stall=0. This overrides load_use and id_halt. Stay in RUN.
  - load_use: stall[1:0]=1, flush[2]=1. If LOAD_LAT>1, go to LSTALL with bub_cnt=LOAD_LAT-1.
  - id_valid & id_halt: stall[1:0]=1, flush[2]=1. Go to DRAIN with drain_cnt=STAGES-3.
  - Otherwise stall=0 and flush=0.
- State LSTALL:
  - Outputs: stall[1:0]=1, flush[2]=1, and bub_cnt decrements.
  - Go to RUN when bub_cnt==1.
  - ex_branch_taken cannot occur here because EX holds a bubble; if it is asserted anyway, the branch rule applies and the next state is RUN.
- State DRAIN:
  - Outputs: stall[1:0]=1, flush[2]=1, and drain_cnt decrements each cycle.
  - At drain_cnt==0, go to HALTED.
  - If ex_branch_taken arrives, the halt is on the wrong path: apply the branch flush, abort the drain and go to RUN.
- State HALTED:
  - Outputs: halted=1, stall=all ones, flush=0.
  - restart=1: go to RUN next cycle and clear halted. The halt instruction is still held in ID.
  - restart is ignored in all other states.
- stall_count:
  - Increments at each edge where any stall bit=1 and state!=HALTED.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- Stall and flush are never both set for the same stage.
- Stages >=3 are never stalled except in HALTED.

Test Plan:
- Load-use: EX load with rd=5; ID add uses rs1=5; LOAD_LAT=1 -> one cycle of stall=00011, flush=00100, then RUN and fwd_rs1=1. Repeat with LOAD_LAT=3 -> 3 bubble cycles, stall_count +3.
- Forwarding priority: mem_rd=7 and wb_rd=7 both writing, id_rs2=7 -> fwd_rs2=1. Drop mem_reg_write -> 2. Set rd=0 on both -> 0.
- Branch over load-use: load_use and ex_branch_taken in the same cycle -> flush=00011, stall=0, state stays RUN.
- Halt drain, STAGES=5: id_halt at cycle 0 -> 2 DRAIN cycles, halted=1 at cycle 3 with stall=11111. restart for 1 cycle -> halted=0 next cycle.
- Branch during DRAIN: id_halt, then ex_branch_taken on the next cycle -> flush=00011, RUN, halted never asserts.
- Reset mid-drain and counter saturation: rst=0 during DRAIN -> RUN, stall_count=0, flush=11111 while low. CNT_W=4 with a permanent load_use stream -> stall_count holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for an N-stage in-order pipeline.
// Stage 0 is IF, stage 1 is ID, stage 2 is EX and so on.
// This block owns every stall, flush, forwarding-select and halt-drain
// decision, and keeps a saturating count of stalled cycles.
module pipe_hazard_ctrl #(
    parameter int STAGES      = 5,
    parameter int FLUSH_DEPTH = 2,
    parameter int LOAD_LAT    = 1,
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_halt,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_is_load,
    input  logic              ex_branch_taken,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic              restart,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic [1:0]        fwd_rs1,
    output logic [1:0]        fwd_rs2,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // Drain length is STAGES-3, which always fits in clog2(STAGES) bits.
    localparam int DRAIN_W = $clog2(STAGES);

    localparam logic [STAGES-1:0]  ALL_ONES     = {STAGES{1'b1}};
    localparam logic [STAGES-1:0]  ALL_ZEROS    = {STAGES{1'b0}};
    localparam logic [STAGES-1:0]  BRANCH_FLUSH = {{(STAGES-FLUSH_DEPTH){1'b0}}, {FLUSH_DEPTH{1'b1}}};
    localparam logic [STAGES-1:0]  HOLD_STALL   = {{(STAGES-2){1'b0}}, 2'b11};
    localparam logic [STAGES-1:0]  BUBBLE_FLUSH = {{(STAGES-3){1'b0}}, 3'b100};
    localparam logic [DRAIN_W-1:0] DRAIN_INIT   = DRAIN_W'(STAGES - 3);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE    = DRAIN_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_ZERO   = DRAIN_W'(0);
    localparam logic [2:0]         BUB_INIT     = 3'(LOAD_LAT - 1);
    localparam logic [2:0]         BUB_ONE      = 3'd1;
    localparam logic [2:0]         BUB_ZERO     = 3'd0;
    localparam logic [REG_AW-1:0]  REG_ZERO     = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [2:0]         bub_cnt_r;
    logic [2:0]         bub_nxt_s;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [DRAIN_W-1:0] drain_nxt_s;
    logic               halted_r;
    logic [CNT_W-1:0]   stall_count_r;
    logic [STAGES-1:0]  stall_s;
    logic [STAGES-1:0]  flush_s;
    logic [1:0]         fwd_rs1_s;
    logic [1:0]         fwd_rs2_s;
    logic               load_use_s;

    // Bypass source for one operand: MEM beats WB, x0 is never bypassed.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              m_en,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_en,
        input logic [REG_AW-1:0] w_rd
    );
        logic [1:0] sel;
        if (m_en && (m_rd != REG_ZERO) && (m_rd == src)) begin
            sel = 2'd1;
        end else if (w_en && (w_rd != REG_ZERO) && (w_rd == src)) begin
            sel = 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Load-use detection: EX load feeding a register ID is about to read.
    always_comb begin
        load_use_s = id_valid && ex_valid && ex_is_load && ex_reg_write &&
                     (ex_rd != REG_ZERO) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // Stall/flush/forward decisions and next-state selection.
    always_comb begin
        stall_s     = ALL_ZEROS;
        flush_s     = ALL_ZEROS;
        fwd_rs1_s   = 2'd0;
        fwd_rs2_s   = 2'd0;
        state_nxt_s = state_r;
        bub_nxt_s   = bub_cnt_r;
        drain_nxt_s = drain_cnt_r;
        if (!rst) begin
            flush_s = ALL_ONES;
        end else begin
            fwd_rs1_s = fwd_sel(id_rs1, mem_valid && mem_reg_write, mem_rd,
                                wb_valid && wb_reg_write, wb_rd);
            fwd_rs2_s = fwd_sel(id_rs2, mem_valid && mem_reg_write, mem_rd,
                                wb_valid && wb_reg_write, wb_rd);
            if ((state_r != ST_HALTED) && ex_branch_taken) begin
                // A taken branch squashes the younger stages and cancels any
                // pending bubble or drain, since those were wrong-path.
                flush_s     = BRANCH_FLUSH;
                state_nxt_s = ST_RUN;
                bub_nxt_s   = BUB_ZERO;
                drain_nxt_s = DRAIN_ZERO;
            end else begin
                case (state_r)
                    ST_RUN: begin
                        if (load_use_s) begin
                            stall_s = HOLD_STALL;
                            flush_s = BUBBLE_FLUSH;
                            if (LOAD_LAT > 1) begin
                                state_nxt_s = ST_LSTALL;
                                bub_nxt_s   = BUB_INIT;
                            end else begin
                                state_nxt_s = ST_RUN;
                            end
                        end else if (id_valid && id_halt) begin
                            stall_s     = HOLD_STALL;
                            flush_s     = BUBBLE_FLUSH;
                            state_nxt_s = ST_DRAIN;
                            drain_nxt_s = DRAIN_INIT;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end
                    ST_LSTALL: begin
                        stall_s   = HOLD_STALL;
                        flush_s   = BUBBLE_FLUSH;
                        bub_nxt_s = bub_cnt_r - BUB_ONE;
                        if (bub_cnt_r <= BUB_ONE) begin
                            state_nxt_s = ST_RUN;
                            bub_nxt_s   = BUB_ZERO;
                        end else begin
                            state_nxt_s = ST_LSTALL;
                        end
                    end
                    ST_DRAIN: begin
                        stall_s = HOLD_STALL;
                        flush_s = BUBBLE_FLUSH;
                        // The halt reaches HALTED as the count steps to zero,
                        // giving exactly STAGES-3 drain cycles.
                        if (drain_cnt_r <= DRAIN_ONE) begin
                            state_nxt_s = ST_HALTED;
                            drain_nxt_s = DRAIN_ZERO;
                        end else begin
                            state_nxt_s = ST_DRAIN;
                            drain_nxt_s = drain_cnt_r - DRAIN_ONE;
                        end
                    end
                    ST_HALTED: begin
                        stall_s = ALL_ONES;
                        if (restart) begin
                            state_nxt_s = ST_RUN;
                        end else begin
                            state_nxt_s = ST_HALTED;
                        end
                    end
                    default: begin
                        stall_s     = ALL_ZEROS;
                        flush_s     = ALL_ONES;
                        state_nxt_s = ST_RUN;
                        bub_nxt_s   = BUB_ZERO;
                        drain_nxt_s = DRAIN_ZERO;
                    end
                endcase
            end
        end
    end

    // State, counters, halted flag and the saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_RUN;
            bub_cnt_r     <= BUB_ZERO;
            drain_cnt_r   <= DRAIN_ZERO;
            halted_r      <= 1'b0;
            stall_count_r <= CNT_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            bub_cnt_r   <= bub_nxt_s;
            drain_cnt_r <= drain_nxt_s;
            halted_r    <= (state_nxt_s == ST_HALTED);
            if ((|stall_s) && (state_r != ST_HALTED) && (stall_count_r != CNT_MAX)) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign stall       = stall_s;
    assign flush       = flush_s;
    assign fwd_rs1     = fwd_rs1_s;
    assign fwd_rs2     = fwd_rs2_s;
    assign halted      = halted_r;
    assign stall_count = stall_count_r;

endmodule
